// File: rtl/alu_uart_if.sv
// alu_uart_if -- framing controller between a UART byte stream and an ALU.
//
// Collects a three-byte frame (A, B, OP) from the receiver. Each byte goes into
// its output register, with a one-cycle load-enable pulse. The design then
// snapshots the ALU result and flags and returns two bytes through the
// transmitter: first the result, then a flag byte {0.., overflow, zero}.
// A partial frame is abandoned if the next byte does not arrive within
// TIMEOUT_CYC cycles.
//
// Ports
//   i_clk, i_rst             clock (rising edge), asynchronous active-low reset
//   i_rx_data, i_rx_done     received byte and its one-cycle valid pulse
//   i_tx_done                transmitter finished the current byte
//   i_alu_result/zero/overflow  ALU outputs, driven from the registered operands
//   o_data_a, o_data_b, o_op operand / opcode values toward the ALU registers
//   o_en_a, o_en_b, o_en_op  one-cycle load enables for those registers
//   o_tx_data, o_tx_start    byte to transmit and its one-cycle start pulse
//   o_busy                   high from LOAD_OP through WAIT_FLG
module alu_uart_if #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic               i_alu_overflow,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_en_a,
    output logic               o_en_b,
    output logic               o_en_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        WAIT_A, WAIT_B, WAIT_OP, LOAD_OP, LATCH,
        SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    state_t             state;
    logic               zero_snap;
    logic               ovf_snap;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;
    logic [NB_DATA-1:0] flag_byte;

    // The counter idles at 0 on entry and reaches CNT_LAST on the
    // TIMEOUT_CYC-th cycle of waiting, so it never needs to wrap.
    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        flag_byte    = '0;
        flag_byte[1] = ovf_snap;
        flag_byte[0] = zero_snap;
    end

    // o_tx_data doubles as the result snapshot: it is loaded from the ALU in
    // LATCH and left untouched until the flag byte replaces it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_en_a     <= 1'b0;
            o_en_b     <= 1'b0;
            o_en_op    <= 1'b0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            zero_snap  <= 1'b0;
            ovf_snap   <= 1'b0;
            cnt        <= '0;
        end else begin
            o_en_a     <= 1'b0;
            o_en_b     <= 1'b0;
            o_en_op    <= 1'b0;
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        o_en_a   <= 1'b1;
                        cnt      <= '0;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte on the timeout cycle still wins over the timeout.
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        o_en_b   <= 1'b1;
                        cnt      <= '0;
                        state    <= WAIT_OP;
                    end else if (timeout) begin
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op    <= i_rx_data[NB_OP-1:0];
                        o_en_op <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= LOAD_OP;
                    end else if (timeout) begin
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOAD_OP: state <= LATCH;
                LATCH: begin
                    o_tx_data  <= i_alu_result;
                    zero_snap  <= i_alu_zero;
                    ovf_snap   <= i_alu_overflow;
                    o_tx_start <= 1'b1;
                    state      <= SEND_RES;
                end
                SEND_RES: state <= WAIT_RES;
                WAIT_RES: begin
                    if (i_tx_done) begin
                        o_tx_data  <= flag_byte;
                        o_tx_start <= 1'b1;
                        state      <= SEND_FLG;
                    end
                end
                SEND_FLG: state <= WAIT_FLG;
                WAIT_FLG: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: operand, result and serial byte width.
REQ-002 SHALL have parameter NB_OP, default 6: opcode width, NB_OP <= NB_DATA.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000: inter-byte timeout in clock cycles, >= 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, as listed in REQ-005 and REQ-006.
REQ-005 i_clk  in  1  clock, all state updates on rising edge.
REQ-006 i_rst  in  1  asynchronous active-low reset.
REQ-007 i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1.
REQ-008 i_rx_done  in  1  one-cycle pulse, received byte available.
REQ-009 i_tx_done  in  1  one-cycle pulse, transmitter finished current byte.
REQ-010 i_alu_result  in  NB_DATA  ALU result, driven from the registered operands.
REQ-011 i_alu_zero, i_alu_overflow  in  1 each  ALU flags.
REQ-012 o_data_a, o_data_b  out  NB_DATA each  operand values toward the operand registers.
REQ-013 o_op  out  NB_OP  opcode toward the opcode register.
REQ-014 o_en_a, o_en_b, o_en_op  out  1 each  one-cycle load-enable pulses.
REQ-015 o_tx_data  out  NB_DATA  byte to transmit.
REQ-016 o_tx_start  out  1  one-cycle pulse, start transmission of o_tx_data.
REQ-017 o_busy  out  1  high while a computed frame is being returned.

Function
REQ-018 Frame SHALL be three received bytes, in order A, B, OP; OP uses bits [NB_OP-1:0], upper bits ignored.
REQ-019 FSM states SHALL be: WAIT_A, WAIT_B, WAIT_OP, LOAD_OP, LATCH, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-020 In WAIT_A/WAIT_B/WAIT_OP, rx_done=1 at edge N SHALL register the byte into o_data_a/o_data_b/o_op.
REQ-021 The matching o_en_* SHALL be 1 for exactly cycle N+1.
REQ-022 The FSM SHALL advance WAIT_A->WAIT_B->WAIT_OP->LOAD_OP; LOAD_OP is the o_en_op cycle.
REQ-023 o_data_a, o_data_b, o_op SHALL hold their values until the next capture of the same field.
REQ-024 LOAD_OP SHALL last one cycle, then LATCH.
REQ-025 LATCH SHALL snapshot i_alu_result, i_alu_zero, i_alu_overflow, then go to SEND_RES.
REQ-026 SEND_RES SHALL drive o_tx_data=snapshot result and o_tx_start=1 for one cycle, then WAIT_RES.
REQ-027 WAIT_RES SHALL wait for i_tx_done, then go to SEND_FLG.
REQ-028 SEND_FLG SHALL drive o_tx_data = zeros, overflow at bit1, zero at bit0, with o_tx_start=1 for one cycle, then WAIT_FLG.
REQ-029 WAIT_FLG SHALL wait for i_tx_done, then go to WAIT_A.
REQ-030 o_busy SHALL be 1 in LOAD_OP through WAIT_FLG inclusive, else 0.
REQ-031 i_rx_done SHALL be ignored while o_busy=1; bytes received then are dropped.
REQ-032 i_tx_done SHALL be ignored outside WAIT_RES and WAIT_FLG.
REQ-033 Timeout counter SHALL clear on entering WAIT_B or WAIT_OP and increment each cycle there.
REQ-034 After TIMEOUT_CYC cycles without rx_done, the FSM SHALL return to WAIT_A with no o_en_op pulse.
REQ-035 On timeout, o_data_* SHALL retain their last values.
REQ-036 If rx_done coincides with the timeout cycle, the byte SHALL be accepted and the timeout discarded.
REQ-037 A counter width of $clog2(TIMEOUT_CYC) bits SHALL suffice; the counter SHALL NOT wrap.

Reset
REQ-038 While i_rst=0, state SHALL be WAIT_A.
REQ-039 While i_rst=0, all outputs, snapshot and counter SHALL be 0.
REQ-040 Reset mid-frame or mid-transmit SHALL abort without further enable or tx_start pulses.
REQ-041 After reset release, the first rx_done SHALL be treated as byte A.

Verification
REQ-042 Rx 0x05, 0x03, 0x20; stub result=0x08, zero=0, ovf=0 -> en_a/en_b/en_op pulses with 0x05/0x03/0x20; tx 0x08 then 0x00.
REQ-043 Rx 0x7F, 0x01, OP; stub result=0x00, zero=1, ovf=1 -> tx 0x00 then 0x03.
REQ-044 Rx 0x11, then no byte for TIMEOUT_CYC cycles -> no en_b/en_op; next 3 bytes form a full new frame.
REQ-045 Rx byte during WAIT_RES -> ignored; tx sequence unchanged; next frame starts clean.
REQ-046 Assert i_rst=0 in WAIT_OP or WAIT_RES -> all outputs 0 asynchronously; after release, frame 0x02, 0x02, OP completes normally.
REQ-047 rx_done on the last timeout cycle in WAIT_B -> byte accepted as B, en_b pulses.
